if_fetch: RTL and testbench

Instruction-fetch front end that produces the `pc`/instruction pair and the bubble/flush indication consumed by the IF/ID pipeline register. It keeps the fetch PC and issues single-outstanding requests to instruction memory over a req/gnt/rvalid handshake. It handles downstream stall by re-presenting the held instruction, and handles branch redirect by discarding in-flight responses. It is the producing end of the IF/ID interface: its outputs connect directly to the register's `pc_i`, `instruct_in` and `flush` inputs.

---
 rtl/core_pkg.sv | 18 +
 rtl/if_pc_gen.sv | 30 +++
 rtl/if_fetch.sv | 148 ++++++++++++++
 tb/tb_if_fetch.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared fetch-side types: FSM states, the default NOP word and the buffer/skid entry.
package core_pkg;

   typedef enum logic [1:0] {F_REQ, F_WAIT, F_HOLD} fetch_state_e;

   localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0033;

   typedef struct packed {
      logic        valid;
      logic [31:0] pc;
      logic [31:0] instr;
   } if_entry_t;

   function automatic logic [31:0] pc_incr(input logic [31:0] pc);
      return pc + 32'd4;
   endfunction

endpackage

// File: rtl/if_pc_gen.sv
// Fetch PC register: holds the next fetch address, advances by 4 per accepted request.
module if_pc_gen
   import core_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        advance,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic [31:0] pc_q
);

   logic [31:0] pc_d;

   always_comb begin
      pc_d = pc_q;
      if (redirect)
         pc_d = redirect_pc;
      else if (advance)
         pc_d = pc_incr(pc_q);
   end

   always_ff @(posedge clk) begin
      if (rst) pc_q <= RESET_PC;
      else     pc_q <= pc_d;
   end

endmodule

// File: rtl/if_fetch.sv
// Instruction-fetch front end feeding the IF/ID register; single outstanding imem request.
// Define IF_FETCH_PERF_EN to add the fetch/bubble performance counters.
module if_fetch
   import core_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic [31:0] pc_o,
   output logic [31:0] instr_o,
   output logic        flush_o
`ifdef IF_FETCH_PERF_EN
   ,
   output logic [31:0] perf_fetch_cnt,
   output logic [31:0] perf_bubble_cnt
`endif
);

   fetch_state_e state_q, state_d;
   if_entry_t    buf_q, buf_d, skid_q, skid_d;
   logic         drop_q, drop_d;
   logic [31:0]  fly_pc_q, fly_pc_d;
   logic [31:0]  pc_q;
   logic         room, gnt_acc, consume;

   assign room      = !buf_q.valid || !stall;
   assign imem_req  = !rst && (state_q == F_REQ) && room;
   assign imem_addr = pc_q;
   assign gnt_acc   = imem_req && imem_gnt;
   assign consume   = buf_q.valid && !stall;

   if_pc_gen #(.RESET_PC(RESET_PC)) u_pc_gen (
      .clk         (clk),
      .rst         (rst),
      .advance     (gnt_acc && !redirect),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .pc_q        (pc_q)
   );

   always_comb begin
      state_d  = state_q;
      buf_d    = buf_q;
      skid_d   = skid_q;
      drop_d   = drop_q;
      fly_pc_d = fly_pc_q;
      if (gnt_acc) fly_pc_d = pc_q;

      if (redirect) begin
         // An already-accepted request still returns data; mark it stale.
         buf_d.valid  = 1'b0;
         skid_d.valid = 1'b0;
         state_d      = F_REQ;
         case (state_q)
            F_REQ: if (gnt_acc) begin
               drop_d  = 1'b1;
               state_d = F_WAIT;
            end
            F_WAIT: if (!imem_rvalid) begin
               drop_d  = 1'b1;
               state_d = F_WAIT;
            end else begin
               drop_d  = 1'b0;
            end
            default: ;
         endcase
      end else begin
         if (consume) buf_d.valid = 1'b0;
         case (state_q)
            F_REQ: if (gnt_acc) state_d = F_WAIT;
            F_WAIT: if (imem_rvalid) begin
               if (drop_q) begin
                  drop_d  = 1'b0;
                  state_d = F_REQ;
               end else if (room) begin
                  buf_d   = '{valid: 1'b1, pc: fly_pc_q, instr: imem_rdata};
                  state_d = F_REQ;
               end else begin
                  skid_d  = '{valid: 1'b1, pc: fly_pc_q, instr: imem_rdata};
                  state_d = F_HOLD;
               end
            end
            F_HOLD: if (!stall) begin
               buf_d        = skid_q;
               buf_d.valid  = 1'b1;
               skid_d.valid = 1'b0;
               state_d      = F_REQ;
            end
            default: state_d = F_REQ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= F_REQ;
         buf_q    <= '0;
         skid_q   <= '0;
         drop_q   <= 1'b0;
         fly_pc_q <= '0;
      end else begin
         state_q  <= state_d;
         buf_q    <= buf_d;
         skid_q   <= skid_d;
         drop_q   <= drop_d;
         fly_pc_q <= fly_pc_d;
      end
   end

   // Outputs are forced to their idle values while reset is held.
   assign pc_o    = rst ? 32'h0 : buf_q.pc;
   assign instr_o = (!rst && buf_q.valid) ? buf_q.instr : NOP_INSTR;
   assign flush_o = rst || !buf_q.valid || redirect;

`ifdef IF_FETCH_PERF_EN
   logic [31:0] fetch_cnt_q, fetch_cnt_d, bubble_cnt_q, bubble_cnt_d;

   // A consumption squashed by a same-cycle redirect never reaches ID.
   always_comb begin
      fetch_cnt_d  = fetch_cnt_q + {31'd0, consume && !redirect};
      bubble_cnt_d = bubble_cnt_q + {31'd0, flush_o};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_cnt_q  <= '0;
         bubble_cnt_q <= '0;
      end else begin
         fetch_cnt_q  <= fetch_cnt_d;
         bubble_cnt_q <= bubble_cnt_d;
      end
   end

   assign perf_fetch_cnt  = fetch_cnt_q;
   assign perf_bubble_cnt = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: hand-derived per-cycle vector table, then random traffic vs a queue model.
module tb_if_fetch;

   localparam logic [31:0] RPC = 32'h0000_1000;
   localparam logic [31:0] NOP = 32'h0000_0033;

   logic        clk = 1'b0, rst = 1'b1, stall = 1'b0, redirect = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt = 1'b0, imem_rvalid = 1'b0;
   logic [31:0] imem_rdata = '0;
   logic [31:0] pc_o, instr_o;
   logic        flush_o;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   if_fetch #(.RESET_PC(RPC), .NOP_INSTR(NOP)) dut (
      .clk(clk), .rst(rst), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
      .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
      .pc_o(pc_o), .instr_o(instr_o), .flush_o(flush_o)
   );

   function automatic logic [31:0] instr_of(input logic [31:0] a);
      return {a[31:2], 2'b11} ^ 32'h5A5A_0000;
   endfunction

   task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s @%0d: got %h want %h", name, idx, act, exp);
      end
   endtask

   task automatic check_outs(input string tag, input int idx, input logic er, input logic [31:0] ea,
                             input logic ef, input logic [31:0] ep, input logic [31:0] ei);
      chk({tag, " imem_req"}, idx, {31'd0, imem_req}, {31'd0, er});
      if (er) chk({tag, " imem_addr"}, idx, imem_addr, ea);
      chk({tag, " flush_o"}, idx, {31'd0, flush_o}, {31'd0, ef});
      chk({tag, " pc_o"}, idx, pc_o, ep);
      chk({tag, " instr_o"}, idx, instr_o, ei);
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      logic        rst, stall, redir;
      logic [31:0] rpc;
      logic        gnt, rvalid;
      logic [31:0] raddr;
      logic        req;
      logic [31:0] addr;
      logic        flush;
      logic [31:0] pc;
      logic        vld;
   } vec_t;
   vec_t vt[$];

   task automatic v(input logic r, input logic s, input logic rd, input logic [31:0] rp,
                    input logic g, input logic rv, input logic [31:0] ra,
                    input logic er, input logic [31:0] ea, input logic ef,
                    input logic [31:0] ep, input logic ev);
      vec_t e;
      e = '{rst: r, stall: s, redir: rd, rpc: rp, gnt: g, rvalid: rv, raddr: ra,
            req: er, addr: ea, flush: ef, pc: ep, vld: ev};
      vt.push_back(e);
   endtask

   // ---------------- random-phase reference model ----------------
   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
   } ent_t;
   ent_t        mq[$];
   logic [31:0] m_next, m_opc, m_last;
   bit          m_out, m_stale;
   bit          mem_pend;
   int          mem_cnt;
   logic [31:0] mem_addr;

   task automatic model_reset();
      m_next   = RPC;
      m_opc    = '0;
      m_last   = '0;
      m_out    = 0;
      m_stale  = 0;
      mq.delete();
      mem_pend = 0;
      mem_cnt  = 0;
   endtask

   initial begin
      logic        er, ef, got_gnt;
      logic [31:0] ep, ei;

      //  rst stl red rpc            gnt rv raddr          req addr           flush pc             vld
      v(1, 0, 0, 32'h0,          0, 0, 32'h0,          0, 32'h0,          1, 32'h0,          0); // reset
      v(0, 0, 0, 32'h0,          1, 0, 32'h0,          1, 32'h1000,       1, 32'h0,          0); // first req
      v(0, 0, 0, 32'h0,          0, 1, 32'h1000,       0, 32'h0,          1, 32'h0,          0);
      v(0, 0, 0, 32'h0,          1, 0, 32'h0,          1, 32'h1004,       0, 32'h1000,       1);
      v(0, 0, 0, 32'h0,          0, 1, 32'h1004,       0, 32'h0,          1, 32'h1000,       0);
      // A request only issues when the buffer is free or draining, so 0x1008 waits for stall to fall.
      v(0, 1, 0, 32'h0,          0, 0, 32'h0,          0, 32'h0,          0, 32'h1004,       1);
      v(0, 1, 0, 32'h0,          0, 0, 32'h0,          0, 32'h0,          0, 32'h1004,       1);
      v(0, 1, 0, 32'h0,          0, 0, 32'h0,          0, 32'h0,          0, 32'h1004,       1);
      v(0, 1, 0, 32'h0,          0, 0, 32'h0,          0, 32'h0,          0, 32'h1004,       1);
      v(0, 0, 0, 32'h0,          1, 0, 32'h0,          1, 32'h1008,       0, 32'h1004,       1);
      v(0, 0, 0, 32'h0,          0, 1, 32'h1008,       0, 32'h0,          1, 32'h1004,       0);
      v(0, 0, 0, 32'h0,          1, 0, 32'h0,          1, 32'h100C,       0, 32'h1008,       1);
      v(0, 0, 1, 32'h2000,       0, 0, 32'h0,          0, 32'h0,          1, 32'h1008,       0); // redirect in F_WAIT
      v(0, 0, 0, 32'h0,          0, 0, 32'h0,          0, 32'h0,          1, 32'h1008,       0);
      v(0, 0, 0, 32'h0,          0, 0, 32'h0,          0, 32'h0,          1, 32'h1008,       0);
      v(0, 0, 0, 32'h0,          0, 1, 32'h100C,       0, 32'h0,          1, 32'h1008,       0); // stale data
      v(0, 0, 0, 32'h0,          0, 0, 32'h0,          1, 32'h2000,       1, 32'h1008,       0); // slow gnt
      v(0, 0, 0, 32'h0,          0, 0, 32'h0,          1, 32'h2000,       1, 32'h1008,       0);
      v(0, 0, 0, 32'h0,          0, 0, 32'h0,          1, 32'h2000,       1, 32'h1008,       0);
      v(0, 0, 0, 32'h0,          1, 0, 32'h0,          1, 32'h2000,       1, 32'h1008,       0);
      v(0, 0, 0, 32'h0,          0, 1, 32'h2000,       0, 32'h0,          1, 32'h1008,       0);
      v(0, 1, 0, 32'h0,          0, 0, 32'h0,          0, 32'h0,          0, 32'h2000,       1);
      v(0, 1, 1, 32'hFFFF_FFFC,  0, 0, 32'h0,          0, 32'h0,          1, 32'h2000,       1); // redirect+stall
      v(0, 1, 0, 32'h0,          1, 0, 32'h0,          1, 32'hFFFF_FFFC,  1, 32'h2000,       0);
      v(0, 0, 0, 32'h0,          0, 1, 32'hFFFF_FFFC,  0, 32'h0,          1, 32'h2000,       0);
      v(0, 0, 0, 32'h0,          1, 0, 32'h0,          1, 32'h0,          0, 32'hFFFF_FFFC,  1); // wrap
      v(0, 0, 1, 32'h3000,       0, 1, 32'h0,          0, 32'h0,          1, 32'hFFFF_FFFC,  0); // redirect+rvalid
      v(0, 0, 1, 32'h4000,       1, 0, 32'h0,          1, 32'h3000,       1, 32'hFFFF_FFFC,  0); // redirect+gnt
      v(0, 0, 0, 32'h0,          0, 1, 32'h3000,       0, 32'h0,          1, 32'hFFFF_FFFC,  0);
      v(0, 0, 0, 32'h0,          1, 0, 32'h0,          1, 32'h4000,       1, 32'hFFFF_FFFC,  0);
      v(1, 0, 0, 32'h0,          0, 0, 32'h0,          0, 32'h0,          1, 32'h0,          0); // mid-txn reset
      v(0, 0, 0, 32'h0,          0, 0, 32'h0,          1, 32'h1000,       1, 32'h0,          0);
      v(0, 0, 0, 32'h0,          1, 0, 32'h0,          1, 32'h1000,       1, 32'h0,          0);
      v(0, 0, 0, 32'h0,          0, 1, 32'h1000,       0, 32'h0,          1, 32'h0,          0);
      v(0, 0, 0, 32'h0,          0, 0, 32'h0,          1, 32'h1004,       0, 32'h1000,       1);

      repeat (2) @(posedge clk);
      #1;
      for (int i = 0; i < vt.size(); i++) begin
         rst         = vt[i].rst;
         stall       = vt[i].stall;
         redirect    = vt[i].redir;
         redirect_pc = vt[i].rpc;
         imem_gnt    = vt[i].gnt;
         imem_rvalid = vt[i].rvalid;
         imem_rdata  = vt[i].rvalid ? instr_of(vt[i].raddr) : 32'hDEAD_BEEF;
         #1;
         check_outs("vec", i, vt[i].req, vt[i].addr, vt[i].flush, vt[i].pc,
                    vt[i].vld ? instr_of(vt[i].pc) : NOP);
         @(posedge clk);
         #1;
      end

      // ---------------- randomized traffic ----------------
      model_reset();
      for (int c = 0; c < 4000; c++) begin
         rst         = (c < 2) || ($urandom_range(0, 199) == 0);
         stall       = ($urandom_range(0, 9) < 3);
         redirect    = ($urandom_range(0, 19) == 0);
         redirect_pc = $urandom() & 32'hFFFF_FFFC;
         if ($urandom_range(0, 3) == 0) redirect_pc = 32'hFFFF_FFFC;
         imem_rvalid = !rst && mem_pend && (mem_cnt == 0);
         imem_rdata  = imem_rvalid ? instr_of(mem_addr) : $urandom();
         imem_gnt    = 1'b0;
         #1;
         imem_gnt = imem_req && !mem_pend && ($urandom_range(0, 9) < 6);
         #1;

         er = !rst && !m_out && (mq.size() == 0 || (mq.size() == 1 && !stall));
         ef = rst || redirect || (mq.size() == 0);
         ep = rst ? 32'h0 : ((mq.size() != 0) ? mq[0].pc : m_last);
         ei = (!rst && mq.size() != 0) ? mq[0].instr : NOP;
         check_outs("rnd", c, er, m_next, ef, ep, ei);

         got_gnt = er && imem_gnt;
         if (rst) begin
            model_reset();
         end else begin
            if (imem_rvalid)   mem_pend = 0;
            else if (mem_pend) mem_cnt--;
            if (imem_gnt) begin
               mem_pend = 1;
               mem_addr = imem_addr;
               mem_cnt  = $urandom_range(0, 2);
            end

            if (redirect) begin
               mq.delete();
               if (got_gnt) begin
                  m_out   = 1;
                  m_stale = 1;
               end else if (m_out) begin
                  if (imem_rvalid) begin
                     m_out   = 0;
                     m_stale = 0;
                  end else begin
                     m_stale = 1;
                  end
               end
               m_next = redirect_pc;
            end else begin
               if (mq.size() != 0 && !stall) void'(mq.pop_front());
               if (imem_rvalid && m_out) begin
                  m_out = 0;
                  if (m_stale) m_stale = 0;
                  else         mq.push_back('{pc: m_opc, instr: instr_of(m_opc)});
               end
               if (got_gnt) begin
                  m_out  = 1;
                  m_opc  = m_next;
                  m_next = m_next + 32'd4;
               end
            end
            if (mq.size() != 0) m_last = mq[0].pc;
         end
         @(posedge clk);
         #1;
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
